// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode constants and register-usage types shared by the hazard logic
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_RA = 5'd31;

    typedef struct packed {
        logic      uses_rs;
        logic      uses_rt;
        logic      writes;
        reg_addr_t dest;
    } reg_usage_t;

endpackage

// File: rtl/mips_reg_usage_decode.sv
// rtl/mips_reg_usage_decode.sv - combinational decode of which registers an instruction reads and writes
module mips_reg_usage_decode
    import mips_pkg::*;
(
    input  logic [31:0] instruction,
    output reg_usage_t  usage
);

    logic [5:0] opcode;
    logic [5:0] funct;
    reg_addr_t  rt;
    reg_addr_t  rd;
    logic       unused_fields;

    assign opcode = instruction[31:26];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign funct  = instruction[5:0];

    // rs and shamt never influence usage; rs is indexed by the scoreboard itself
    assign unused_fields = ^{instruction[25:21], instruction[10:6]};

    always_comb begin
        usage = '0;
        case (opcode)
            OP_RTYPE: begin
                usage.uses_rs = 1'b1;
                usage.uses_rt = 1'b1;
                if (funct != FUNCT_JR) begin
                    usage.writes = 1'b1;
                    usage.dest   = rd;
                end
            end
            OP_LW: begin
                usage.uses_rs = 1'b1;
                usage.writes  = 1'b1;
                usage.dest    = rt;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                usage.uses_rs = 1'b1;
                usage.uses_rt = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                usage.uses_rs = 1'b1;
                usage.writes  = 1'b1;
                usage.dest    = rt;
            end
            OP_LUI: begin
                usage.writes = 1'b1;
                usage.dest   = rt;
            end
            OP_JAL: begin
                usage.writes = 1'b1;
                usage.dest   = REG_RA;
            end
            default: begin
                usage = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register write-in-flight tracking and decode stall generation
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int P_WB_LATENCY  = 3,
    parameter int P_STALL_CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              ip_instruction,
    input  logic                     ip_valid,
    input  logic                     ip_flush,
    output logic                     op_stall,
    output logic [31:0]              op_pending,
    output logic [P_STALL_CNT_W-1:0] op_stall_count
);

    localparam logic [2:0] WB_LOAD = 3'(P_WB_LATENCY);

    reg_usage_t usage;
    reg_addr_t  rs;
    reg_addr_t  rt;
    logic [2:0] cnt [32];
    logic       hazard_rs;
    logic       hazard_rt;
    logic       issue;

    mips_reg_usage_decode u_decode (
        .instruction (ip_instruction),
        .usage       (usage)
    );

    assign rs = ip_instruction[25:21];
    assign rt = ip_instruction[20:16];

    always_comb begin
        op_pending = '0;
        for (int r = 1; r < 32; r++) begin
            op_pending[r] = (cnt[r] != 3'd0);
        end
    end

    // r0 is hardwired, so reading it can never be a hazard
    assign hazard_rs = usage.uses_rs && (rs != '0) && op_pending[rs];
    assign hazard_rt = usage.uses_rt && (rt != '0) && op_pending[rt];

    assign op_stall = ip_valid & ~ip_flush & ~reset & (hazard_rs | hazard_rt);
    assign issue    = ip_valid & ~ip_flush & ~op_stall;

    // A fresh issue reloads the counter, which also covers back-to-back writes to one register
    always_ff @(posedge clock) begin
        cnt[0] <= 3'd0;
        if (reset) begin
            for (int r = 1; r < 32; r++) begin
                cnt[r] <= 3'd0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (issue && usage.writes && (usage.dest == reg_addr_t'(r))) begin
                    cnt[r] <= WB_LOAD;
                end else if (cnt[r] != 3'd0) begin
                    cnt[r] <= cnt[r] - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_stall_count <= '0;
        end else if (op_stall && (op_stall_count != '1)) begin
            op_stall_count <= op_stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed checks of hazard_scoreboard against a timeline model
module tb_hazard_scoreboard;

    localparam int L       = 3;
    localparam int CNT_MAX = 65535;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ip_instruction;
    logic        ip_valid;
    logic        ip_flush;
    logic        op_stall;
    logic [31:0] op_pending;
    logic [15:0] op_stall_count;

    logic        s_reset;
    logic [31:0] s_instruction;
    logic        s_valid;
    logic        s_flush;
    logic        s_stall;
    logic [31:0] s_pending;
    logic [11:0] s_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each register remembers the edge number after which its write has landed
    int unsigned edge_no = 0;
    int unsigned wb_edge [32];
    int unsigned m_cnt = 0;
    bit          model_init = 0;

    always #5 clock = ~clock;

    hazard_scoreboard #(.P_WB_LATENCY(L), .P_STALL_CNT_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .ip_instruction (ip_instruction),
        .ip_valid       (ip_valid),
        .ip_flush       (ip_flush),
        .op_stall       (op_stall),
        .op_pending     (op_pending),
        .op_stall_count (op_stall_count)
    );

    hazard_scoreboard #(.P_WB_LATENCY(7), .P_STALL_CNT_W(12)) u_sat (
        .clock          (clock),
        .reset          (s_reset),
        .ip_instruction (s_instruction),
        .ip_valid       (s_valid),
        .ip_flush       (s_flush),
        .op_stall       (s_stall),
        .op_pending     (s_pending),
        .op_stall_count (s_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_usage(input logic [31:0] ins, output logic [31:0] rmask, output logic [4:0] wd);
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        rd = ins[15:11];
        rmask = '0;
        wd = '0;
        if (op == 6'h00) begin
            rmask[rs] = 1'b1;
            rmask[rt] = 1'b1;
            if (ins[5:0] != 6'h08) wd = rd;
        end else if (op == 6'h23) begin
            rmask[rs] = 1'b1;
            wd = rt;
        end else if (op == 6'h2B || op == 6'h04 || op == 6'h05) begin
            rmask[rs] = 1'b1;
            rmask[rt] = 1'b1;
        end else if (op >= 6'h08 && op <= 6'h0E) begin
            rmask[rs] = 1'b1;
            wd = rt;
        end else if (op == 6'h0F) begin
            wd = rt;
        end else if (op == 6'h03) begin
            wd = 5'd31;
        end
        rmask[0] = 1'b0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        for (int i = 1; i < 32; i++) p[i] = (edge_no < wb_edge[i]);
        return p;
    endfunction

    task automatic cycle(input logic [31:0] instr, input logic v, input logic f, input logic r);
        logic [31:0] rmask;
        logic [4:0]  wd;
        logic        exp_stall;
        ip_instruction = instr;
        ip_valid = v;
        ip_flush = f;
        reset = r;
        model_usage(instr, rmask, wd);
        exp_stall = v && !f && !r && ((rmask & model_pending()) != 0);
        @(negedge clock);
        if (model_init || r) check("stall", op_stall, exp_stall);
        if (model_init) begin
            check("pending", op_pending, model_pending());
            check("stall_count", op_stall_count, m_cnt);
        end
        @(posedge clock);
        if (r) begin
            for (int i = 0; i < 32; i++) wb_edge[i] = 0;
            m_cnt = 0;
            model_init = 1;
        end else begin
            if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
            if (v && !f && !exp_stall && wd != 0) wb_edge[wd] = edge_no + 1 + L;
        end
        edge_no++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0] ops [16];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09,
                6'h0A, 6'h0C, 6'h0E, 6'h0F, 6'h02, 6'h03, 6'h3F, 6'h23};
        op = ops[$urandom_range(0, 15)];
        fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20;
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'd0, fn};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) wb_edge[i] = 0;
        s_reset = 1'b1;
        s_instruction = '0;
        s_valid = 1'b0;
        s_flush = 1'b0;

        // 1: reset and idle
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("t1_pending", op_pending, 32'h0);
        check("t1_count", op_stall_count, 16'h0);

        // 2: add $3 then dependent add $4,$3,$3
        cycle(32'h00221820, 1'b1, 1'b0, 1'b0);
        check("t2_pend3", op_pending[3], 1'b1);
        for (int i = 0; i < 4; i++) cycle(32'h00632020, 1'b1, 1'b0, 1'b0);
        check("t2_count", op_stall_count, 16'd3);
        check("t2_pend4", op_pending[4], 1'b1);
        idle(4);

        // 3: lw $5 then sw reading $5 via rt, then a hazard-free add
        cycle(32'h8C250000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(32'hAC450004, 1'b1, 1'b0, 1'b0);
        cycle(32'h00002020, 1'b1, 1'b0, 1'b0);
        check("t3_count", op_stall_count, 16'd6);
        idle(4);

        // 4: writes to r0 are never tracked
        cycle(32'h00220020, 1'b1, 1'b0, 1'b0);
        check("t4_pending", op_pending, 32'h0);
        cycle(32'h00002020, 1'b1, 1'b0, 1'b0);
        idle(4);

        // 5: flushed writer leaves nothing; flushed reader never stalls
        cycle(32'h00221820, 1'b1, 1'b1, 1'b0);
        check("t5_no_entry", op_pending[3], 1'b0);
        cycle(32'h00632020, 1'b1, 1'b0, 1'b0);
        idle(4);
        cycle(32'h00221820, 1'b1, 1'b0, 1'b0);
        cycle(32'h00632020, 1'b1, 1'b1, 1'b0);
        idle(4);

        // reset while a reader is stalled
        cycle(32'h00221820, 1'b1, 1'b0, 1'b0);
        cycle(32'h00632020, 1'b1, 1'b0, 1'b0);
        cycle(32'h00632020, 1'b1, 1'b0, 1'b1);
        check("rst_pending", op_pending, 32'h0);
        check("rst_count", op_stall_count, 16'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(gen_instr(), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 299) == 0));
        end
        ip_valid = 1'b0;

        // 6: saturation on a narrow counter, writer reissued each time the entry would expire
        begin
            int exp_s;
            @(negedge clock);
            @(posedge clock);
            #1;
            s_reset = 1'b0;
            s_valid = 1'b1;
            exp_s = 0;
            for (int g = 0; g < 600; g++) begin
                s_instruction = 32'h00221820;
                @(negedge clock);
                check("sat_wr_stall", s_stall, 1'b0);
                @(posedge clock);
                #1;
                for (int k = 0; k < 7; k++) begin
                    s_instruction = 32'h00632020;
                    @(negedge clock);
                    check("sat_rd_stall", s_stall, 1'b1);
                    @(posedge clock);
                    #1;
                    if (exp_s < 4095) exp_s++;
                end
                if (g % 50 == 0) check("sat_count", s_count, exp_s);
            end
            check("sat_hold", s_count, 12'hFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
